// File: rtl/tmr_minority_monitor.sv
// tmr_minority_monitor: registered TMR minority vote with per-channel fault masking and health FSM
module tmr_minority_monitor #(
  parameter int THRESH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       clear,
  output logic       y,
  output logic       y_valid,
  output logic [2:0] fault_mask,
  output logic [1:0] state,
  output logic       err
);
  typedef enum logic [1:0] {NORMAL = 2'b00, DEGRADED = 2'b01, FAILED = 2'b10} state_t;
  localparam logic [3:0] TH = 4'(THRESH);
  state_t st, st_d;
  logic [2:0][3:0] run, run_d, run_n;
  logic [3:0] mrun, mrun_d, mrun_n;
  logic [2:0] abc, dis, hit, mask_d;
  logic y_d, v_d, minority, p, q;
  function automatic logic [3:0] inc(input logic [3:0] v);
    return v == 4'hf ? v : v + 4'd1;
  endfunction
  assign abc = {c, b, a};
  assign minority = (~a & ~b) | (~a & ~c) | (~b & ~c);
  assign dis = abc ^ {3{~minority}};
  assign p = fault_mask[0] ? b : a;
  assign q = fault_mask[2] ? b : c;
  assign mrun_n = p == q ? 4'd0 : inc(mrun);
  for (genvar i = 0; i < 3; i++) begin : g_run
    assign run_n[i] = dis[i] ? inc(run[i]) : 4'd0;
    assign hit[i] = dis[i] && run_n[i] == TH;
  end
  always_comb begin
    st_d = st;
    mask_d = fault_mask;
    run_d = run;
    mrun_d = mrun;
    y_d = y;
    v_d = 1'b0;
    if (clear) begin
      st_d = NORMAL;
      mask_d = '0;
      run_d = '0;
      mrun_d = '0;
      y_d = 1'b0;
    end else if (in_valid) begin
      v_d = 1'b1;
      if (st == NORMAL) begin
        y_d = minority;
        run_d = |hit ? '0 : run_n;
        mask_d = hit;
        st_d = |hit ? DEGRADED : NORMAL;
      end else if (st == DEGRADED) begin
        y_d = p == q ? ~p : y;
        mrun_d = mrun_n;
        mask_d = mrun_n == TH ? 3'b111 : fault_mask;
        st_d = mrun_n == TH ? FAILED : DEGRADED;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= NORMAL;
      fault_mask <= '0;
      run <= '0;
      mrun <= '0;
      y <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      st <= st_d;
      fault_mask <= mask_d;
      run <= run_d;
      mrun <= mrun_d;
      y <= y_d;
      y_valid <= v_d;
    end
  end
  assign state = st;
  assign err = st == FAILED;
endmodule

// File: tb/tb_tmr_minority_monitor.sv
// tb_tmr_minority_monitor: directed and randomized scoreboard bench against a counting reference model
module tb_tmr_minority_monitor;
  localparam int TH = 4;
  logic clk = 1'b0;
  logic reset, in_valid, a, b, c, clear;
  logic y, y_valid, err;
  logic [2:0] fault_mask;
  logic [1:0] state;
  typedef struct packed {logic y; logic [1:0] st; logic [2:0] mask; logic err;} exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int ms, mc;
  int cnt[3];
  logic [2:0] mmask;
  logic my;
  always #5 clk = ~clk;
  tmr_minority_monitor #(.THRESH(TH)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .a(a),
    .b(b),
    .c(c),
    .clear(clear),
    .y(y),
    .y_valid(y_valid),
    .fault_mask(fault_mask),
    .state(state),
    .err(err)
  );
  function automatic void chk(string n, int act, int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", n, act, expv, $time);
    end
  endfunction
  function automatic void model_reset();
    ms = 0;
    mc = 0;
    mmask = 3'b000;
    my = 1'b0;
    cnt = '{0, 0, 0};
  endfunction
  task automatic drive(input logic v, input logic [2:0] abc, input logic clr, input logic rst);
    int zeros;
    int bits[3];
    int up[$];
    logic [2:0] hitm;
    in_valid = v;
    {a, b, c} = abc;
    clear = clr;
    reset = rst;
    bits[0] = int'(abc[2]);
    bits[1] = int'(abc[1]);
    bits[2] = int'(abc[0]);
    if (rst || clr) begin
      model_reset();
    end else if (v) begin
      if (ms == 0) begin
        zeros = (bits[0] == 0 ? 1 : 0) + (bits[1] == 0 ? 1 : 0) + (bits[2] == 0 ? 1 : 0);
        my = zeros >= 2;
        hitm = 3'b000;
        for (int i = 0; i < 3; i++) begin
          if (bits[i] != (my ? 0 : 1)) begin
            cnt[i] = cnt[i] < 15 ? cnt[i] + 1 : 15;
            if (cnt[i] == TH) hitm[i] = 1'b1;
          end else begin
            cnt[i] = 0;
          end
        end
        if (hitm != 3'b000) begin
          mmask = hitm;
          ms = 1;
          cnt = '{0, 0, 0};
        end
      end else if (ms == 1) begin
        for (int i = 0; i < 3; i++) if (!mmask[i]) up.push_back(bits[i]);
        if (up[0] == up[1]) begin
          my = up[0] == 0;
          mc = 0;
        end else begin
          mc = mc < 15 ? mc + 1 : 15;
          if (mc == TH) begin
            ms = 2;
            mmask = 3'b111;
          end
        end
      end
      exp_q.push_back('{y: my, st: 2'(ms), mask: mmask, err: ms == 2});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear = 1'b0;
    reset = 1'b0;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (y_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_y_valid", int'(y_valid), 0);
      end else begin
        e = exp_q.pop_front();
        chk("y", int'(y), int'(e.y));
        chk("state", int'(state), int'(e.st));
        chk("mask", int'(fault_mask), int'(e.mask));
        chk("err", int'(err), int'(e.err));
      end
    end
  end
  task automatic status(string n, int yv, int yy, int st, int mk, int er);
    chk({n, "_y_valid"}, int'(y_valid), yv);
    chk({n, "_y"}, int'(y), yy);
    chk({n, "_state"}, int'(state), st);
    chk({n, "_mask"}, int'(fault_mask), mk);
    chk({n, "_err"}, int'(err), er);
  endtask
  initial begin
    int bad;
    logic [2:0] flip;
    logic base;
    in_valid = 1'b0;
    {a, b, c} = 3'b000;
    clear = 1'b0;
    reset = 1'b1;
    model_reset();
    drive(1'b0, 3'b000, 1'b0, 1'b1);
    drive(1'b1, 3'b000, 1'b0, 1'b1);
    status("reset", 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive(1'b1, 3'(i), 1'b0, 1'b0);
    drive(1'b0, 3'b000, 1'b0, 1'b0);
    status("sweep", 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(1'b1, 3'b100, 1'b0, 1'b0);
    status("degrade", 1, 1, 1, 1, 0);
    for (int i = 0; i < 4; i++) drive(1'b1, 3'b010, 1'b0, 1'b0);
    status("fail", 1, 1, 2, 7, 1);
    for (int i = 0; i < 3; i++) drive(1'b1, 3'($urandom_range(0, 7)), 1'b0, 1'b0);
    drive(1'b0, 3'b000, 1'b0, 1'b0);
    status("frozen", 0, 1, 2, 7, 1);
    drive(1'b1, 3'b000, 1'b1, 1'b0);
    status("clear", 0, 0, 0, 0, 0);
    drive(1'b1, 3'b001, 1'b0, 1'b0);
    drive(1'b0, 3'b000, 1'b0, 1'b0);
    status("after_clear", 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1'b1, 3'b100, 1'b0, 1'b0);
    drive(1'b1, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 3'b100, 1'b0, 1'b0);
    status("restart", 1, 1, 0, 0, 0);
    drive(1'b1, 3'b100, 1'b0, 1'b0);
    status("degrade2", 1, 1, 1, 1, 0);
    drive(1'b1, 3'b111, 1'b0, 1'b1);
    status("mid_reset", 0, 0, 0, 0, 0);
    bad = 3;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) bad = $urandom_range(0, 3);
      base = 1'($urandom_range(0, 1));
      flip = 3'b000;
      for (int i = 0; i < 3; i++)
        if ((i == bad) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0)) flip[2 - i] = 1'b1;
      drive(1'($urandom_range(0, 3) != 0), {3{base}} ^ flip, 1'($urandom_range(0, 79) == 0),
            1'($urandom_range(0, 299) == 0));
    end
    repeat (3) drive(1'b0, 3'b000, 1'b0, 1'b0);
    chk("drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tmr_minority_monitor.md
Name: tmr_minority_monitor

Overview:
- Sequential stage directly downstream of the three-input minority gate.
- Samples three redundant bits a, b, c on each valid cycle and produces a registered minority result, y = 1 when at least two inputs are 0.
- Tracks per-channel disagreement against the vote and masks a channel that stays wrong for THRESH consecutive samples.
- Runs a NORMAL / DEGRADED / FAILED state machine so the consumer knows how trustworthy y is.

Parameters:
- THRESH, 4, consecutive disagreeing valid samples before a channel is declared faulty. Legal range 1..15; the run counters are 4 bits wide.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  a/b/c carry a sample this cycle
- a  input  1  channel 0 bit
- b  input  1  channel 1 bit
- c  input  1  channel 2 bit
- clear  input  1  one-cycle pulse: return to NORMAL, clear masks and counters
- y  output  1  registered vote result
- y_valid  output  1  y updated this cycle
- fault_mask  output  3  bit0=a, bit1=b, bit2=c; 1 = channel masked
- state  output  2  00 NORMAL, 01 DEGRADED, 10 FAILED
- err  output  1  asserted while state is FAILED

Behaviour:
- Reset: the following take their reset values on the first clk edge with reset=1, and reset has priority over everything.
  - y=0, y_valid=0, fault_mask=000, state=NORMAL, err=0.
  - All run counters = 0.
  - Reset mid-stream discards any in-flight sample.
- Latency: sample accepted on edge N → y/y_valid visible after edge N; exactly 1 cycle.
- y_valid=1 only in the cycle after an accepted in_valid; otherwise 0. y holds its last value while y_valid=0.
- clear (no reset): same register effect as reset. It has priority over in_valid in the same cycle, and that sample is dropped (y_valid=0 next cycle).
- NORMAL:
  - y = ~a&~b | ~a&~c | ~b&~c.
  - Majority m = ~y.
  - Per channel i: if bit_i != m, run_i increments, saturating at 15; otherwise run_i is set to 0.
  - Only one channel can disagree per sample.
  - When run_i reaches THRESH, on the same edge: fault_mask[i] is set, state becomes DEGRADED, all run counters are set to 0.
  - y for that sample is still the 3-input minority.
- DEGRADED: let p, q be the two unmasked bits.
  - If p == q: y = ~p, and the mismatch run counter is set to 0.
  - If p != q: y holds its previous value, y_valid still pulses, and the mismatch run counter increments.
  - When the mismatch run reaches THRESH: state becomes FAILED and fault_mask becomes 111.
- FAILED: err=1.
  - y holds its value; y_valid continues to pulse on each in_valid, with y frozen.
  - No counters change.
  - Only clear or reset leaves FAILED.
- in_valid=0: no counters change and there is no state transition (except clear/reset).
- THRESH=1: the first disagreeing sample masks the channel (or fails in DEGRADED).
- fault_mask is sticky; it changes only on threshold events, clear, or reset.

Test Plan:
- Reset, then in_valid with {a,b,c} = 000..111 sequentially (8 cycles) → y sequence 1,1,1,0,1,0,0,0, one cycle delayed; y_valid high 8 cycles; state stays 00.
- THRESH=4; hold a=1, b=0, c=0 for 4 valid samples → y=1 each sample; after 4th edge fault_mask=001, state=01.
- Same as previous but 3 disagreeing samples, then 1 agreeing (000), then 3 disagreeing → counter restarts, fault_mask stays 000, state 00.
- From DEGRADED with a masked, drive b=1,c=0 for 4 samples → y holds prior value; after 4th, state=10, err=1, fault_mask=111; further samples keep y frozen with y_valid pulsing.
- In FAILED, assert clear together with in_valid → next cycle state=00, fault_mask=000, err=0, y=0, y_valid=0; next sample {0,0,1} → y=1.
- Assert reset mid-run in DEGRADED with in_valid=1 → after edge, all outputs at reset values and y_valid=0.
